// File: rtl/sort_frame_builder.sv
// sort_frame_builder
//   Ingress side of the odd-even merge sort network. Each input port feeds a
//   small per-lane FIFO. Once per cycle, whenever the frame stage is free and
//   any FIFO holds a word, one sort frame is assembled: every lane contributes
//   either its FIFO head or a filler word that sorts last. The frame is held in
//   a single frame_valid/frame_ready register stage toward the sorter.
//
//   Ports
//     clk, rst     rising-edge clock, synchronous active-high reset
//     in_valid     per-lane word offered          [PORT_NUB]
//     in_ready     per-lane FIFO can accept       [PORT_NUB] (registered)
//     in_dst       per-lane destination port      [PORT_NUB*AW], lane i at [i*AW +: AW]
//     in_data      per-lane payload               [PORT_NUB*DATA_WIDTH]
//     frame_out    sort frame                     [PORT_NUB*W], lane i at [i*W +: W]
//     frame_valid  frame_out holds a frame
//     frame_ready  sorter accepts the frame this cycle
//     frame_cnt    frames accepted by the sorter, wraps at 2^16
//
//   Sort word layout (MSB first): {valid, dst, src, data}; the sorter keys on
//   {valid, dst}.

// Per-lane FIFO plus sort-word formatting for one lane.
//   push_valid/push_dst/push_data  incoming word
//   push_ready                     registered "not full"
//   pop                            frame register loads this cycle
//   nonempty                       FIFO head is valid
//   word                           sort word this lane contributes on load
module sort_frame_lane #(
  parameter int AW         = 3,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int LANE       = 0,
  localparam int W         = 1 + 2*AW + DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  input  logic [AW-1:0]         push_dst,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  push_ready,
  output logic                  nonempty,
  output logic [W-1:0]          word
);
  localparam int AW_F = $clog2(FIFO_DEPTH);
  localparam logic [AW_F:0] FULL = (AW_F+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] SRC  = AW'(LANE);

  typedef struct packed {
    logic [AW-1:0]         dst;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  typedef struct packed {
    logic                  vld;
    logic [AW-1:0]         dst;
    logic [AW-1:0]         src;
    logic [DATA_WIDTH-1:0] data;
  } sort_word_t;

  entry_t            mem [FIFO_DEPTH];
  entry_t            head;
  logic [AW_F-1:0]   wr_ptr, rd_ptr;
  logic [AW_F:0]     cnt, cnt_nxt;
  logic              push, pop_eff;
  sort_word_t        sw;

  assign push     = push_valid & push_ready;
  assign nonempty = (cnt != '0);
  assign pop_eff  = pop & nonempty;
  assign cnt_nxt  = cnt + (AW_F+1)'(push) - (AW_F+1)'(pop_eff);
  assign head     = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{dst: push_dst, data: push_data};
  end

  // push_ready is computed from the next count so it is a pure register
  // toward the input side. It is held low while rst is asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      push_ready <= 1'b0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
      cnt        <= cnt_nxt;
      push_ready <= (cnt_nxt != FULL);
    end
  end

  // Empty lanes emit a filler with valid=0 and dst=all ones so it sorts last.
  always_comb begin
    sw.src = SRC;
    if (nonempty) begin
      sw.vld  = 1'b1;
      sw.dst  = head.dst;
      sw.data = head.data;
    end else begin
      sw.vld  = 1'b0;
      sw.dst  = '1;
      sw.data = '0;
    end
  end

  assign word = sw;
endmodule

module sort_frame_builder #(
  parameter int PORT_NUB   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = $clog2(PORT_NUB),
  localparam int W         = 1 + 2*AW + DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PORT_NUB-1:0]            in_valid,
  output logic [PORT_NUB-1:0]            in_ready,
  input  logic [PORT_NUB*AW-1:0]         in_dst,
  input  logic [PORT_NUB*DATA_WIDTH-1:0] in_data,
  output logic [PORT_NUB*W-1:0]          frame_out,
  output logic                           frame_valid,
  input  logic                           frame_ready,
  output logic [15:0]                    frame_cnt
);
  logic [PORT_NUB-1:0]        lane_ne;
  logic [PORT_NUB-1:0][W-1:0] lane_word;
  logic [PORT_NUB-1:0][W-1:0] frame_q;
  logic                       load;

  for (genvar i = 0; i < PORT_NUB; i++) begin : g_lane
    sort_frame_lane #(
      .AW(AW), .DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .LANE(i)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .push_valid (in_valid[i]),
      .push_dst   (in_dst[i*AW +: AW]),
      .push_data  (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .pop        (load),
      .push_ready (in_ready[i]),
      .nonempty   (lane_ne[i]),
      .word       (lane_word[i])
    );
  end

  // Frame stage is free when empty or being drained; load only if at least
  // one lane has real data, so all-filler frames are never emitted.
  assign load = (~frame_valid | frame_ready) & (|lane_ne);

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q     <= '0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      if (load) frame_q <= lane_word;
      frame_valid <= load | (frame_valid & ~frame_ready);
      if (frame_valid & frame_ready) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign frame_out = frame_q;
endmodule

// File: tb/tb_sort_frame_builder.sv
module tb_sort_frame_builder;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int W  = 1 + 2*AW + DW;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic [N*AW-1:0]   in_dst;
  logic [N*DW-1:0]   in_data;
  logic [N*W-1:0]    frame_out;
  logic              frame_valid;
  logic              frame_ready;
  logic [15:0]       frame_cnt;

  int checks = 0;
  int errors = 0;

  sort_frame_builder #(.PORT_NUB(N), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_dst(in_dst), .in_data(in_data), .frame_out(frame_out),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] sw(input logic v, input logic [AW-1:0] d,
                                      input logic [AW-1:0] s, input logic [DW-1:0] x);
    return {v, d, s, x};
  endfunction

  function automatic logic [W-1:0] fill(input int i);
    return sw(1'b0, 3'd7, AW'(i), '0);
  endfunction

  function automatic logic [W-1:0] lane(input int i);
    return frame_out[i*W +: W];
  endfunction

  // Advance one edge; inputs and checks happen 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic v, input logic [AW-1:0] d,
                          input logic [DW-1:0] x);
    in_valid[i]          = v;
    in_dst[i*AW +: AW]   = d;
    in_data[i*DW +: DW]  = x;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  function automatic logic [DW-1:0] t2d(input int i, input int k);
    return DW'((i << 16) | k);
  endfunction

  function automatic logic [AW-1:0] t2a(input int i, input int k);
    return AW'((i + k) & 7);
  endfunction

  initial begin
    int acc;
    logic rdy;
    rst = 1'b1;
    in_valid = '0;
    in_dst = '0;
    in_data = '0;
    frame_ready = 1'b1;
    #1;

    // T1: reset state, single word latency and filler lanes
    step();
    step();
    chk("rst_fv", frame_valid, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_frame_l0", lane(0), 0);
    rst = 1'b0;
    step();
    chk("rdy_after_rst", in_ready, 8'hff);
    set_lane(3, 1'b1, 3'd5, 32'hA5A5A5A5);
    step();
    in_valid = '0;
    chk("t1_no_bypass", frame_valid, 0);
    step();
    chk("t1_fv", frame_valid, 1);
    for (int i = 0; i < N; i++)
      chk($sformatf("t1_lane%0d", i), lane(i),
          (i == 3) ? sw(1'b1, 3'd5, 3'd3, 32'hA5A5A5A5) : fill(i));
    step();
    chk("t1_cnt", frame_cnt, 1);
    chk("t1_fv_low", frame_valid, 0);

    // T2: all lanes streaming, one frame per cycle
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < N; i++) set_lane(i, 1'b1, t2a(i, k), t2d(i, k));
      step();
      chk($sformatf("t2_rdy_%0d", k), in_ready, 8'hff);
      if (k > 0) begin
        chk($sformatf("t2_fv_%0d", k), frame_valid, 1);
        for (int i = 0; i < N; i++)
          chk($sformatf("t2_k%0d_l%0d", k, i), lane(i),
              sw(1'b1, t2a(i, k-1), AW'(i), t2d(i, k-1)));
      end
    end
    in_valid = '0;
    step();
    for (int i = 0; i < N; i++)
      chk($sformatf("t2_last_l%0d", i), lane(i), sw(1'b1, t2a(i, 19), AW'(i), t2d(i, 19)));
    step();
    chk("t2_fv_low", frame_valid, 0);
    chk("t2_cnt", frame_cnt, 21);

    // T3: backpressure fills lane 0, then drains in order
    frame_ready = 1'b0;
    acc = 0;
    for (int j = 0; j < 6; j++) begin
      set_lane(0, 1'b1, 3'd2, DW'(100 + acc));
      rdy = in_ready[0];
      step();
      if (rdy) acc++;
      if (j > 0) chk($sformatf("t3_hold_%0d", j), lane(0), sw(1'b1, 3'd2, 3'd0, 32'd100));
    end
    in_valid = '0;
    chk("t3_accepted", acc, 5);
    chk("t3_rdy_low", in_ready[0], 0);
    chk("t3_fv", frame_valid, 1);
    frame_ready = 1'b1;
    step();
    chk("t3_rdy_rise", in_ready[0], 1);
    for (int j = 1; j <= 4; j++) begin
      if (j > 1) step();
      chk($sformatf("t3_order_%0d", j), lane(0), sw(1'b1, 3'd2, 3'd0, DW'(100 + j)));
      chk($sformatf("t3_fill1_%0d", j), lane(1), fill(1));
    end
    step();
    chk("t3_drained", frame_valid, 0);

    // T4: full FIFO with push and pop in the same cycle
    frame_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      set_lane(1, 1'b1, 3'd4, DW'(200 + j));
      step();
    end
    set_lane(1, 1'b1, 3'd4, 32'd205);
    frame_ready = 1'b1;
    chk("t4_full_rdy", in_ready[1], 0);
    step();
    chk("t4_pop", lane(1), sw(1'b1, 3'd4, 3'd1, 32'd201));
    chk("t4_rdy_rise", in_ready[1], 1);
    frame_ready = 1'b0;
    step();
    in_valid = '0;
    chk("t4_refull", in_ready[1], 0);
    chk("t4_hold", lane(1), sw(1'b1, 3'd4, 3'd1, 32'd201));
    frame_ready = 1'b1;
    for (int j = 202; j <= 205; j++) begin
      step();
      chk($sformatf("t4_drain_%0d", j), lane(1), sw(1'b1, 3'd4, 3'd1, DW'(j)));
    end
    step();
    chk("t4_drained", frame_valid, 0);

    // T5: frame counter wrap
    do_reset();
    chk("t5_cnt0", frame_cnt, 0);
    set_lane(0, 1'b1, 3'd1, 32'h1);
    for (int n = 1; n <= 65537; n++) step();
    chk("t5_cnt_max", frame_cnt, 16'hffff);
    step();
    chk("t5_wrap", frame_cnt, 0);
    in_valid = '0;

    // T6: reset mid-operation discards everything
    do_reset();
    frame_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      set_lane(2, 1'b1, 3'd0, DW'(300 + j));
      set_lane(4, 1'b1, 3'd1, DW'(400 + j));
      set_lane(6, 1'b1, 3'd2, DW'(600 + j));
      step();
    end
    in_valid = '0;
    chk("t6_pre_fv", frame_valid, 1);
    rst = 1'b1;
    step();
    chk("t6_fv", frame_valid, 0);
    chk("t6_frame_l2", lane(2), 0);
    chk("t6_rdy", in_ready, 0);
    rst = 1'b0;
    frame_ready = 1'b1;
    step();
    chk("t6_rdy_back", in_ready, 8'hff);
    step();
    chk("t6_no_stale_a", frame_valid, 0);
    step();
    chk("t6_no_stale_b", frame_valid, 0);
    chk("t6_cnt", frame_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
